ps2_kbd_rx: RTL and testbench
=============================

// Module: ps2_kbd_rx
// PURPOSE
//  Receives the emulated PS/2 keyboard stream (ps2_kbd_clk/ps2_kbd_data) from the HPS I/O block.
//  Checks each frame and decodes the set-2 scancode prefixes.
//  Outputs are raw bytes plus a key-event word; ps2_key[10] toggles once per event.
//  Sits between the HPS I/O block and the core's keyboard matrix/translator. Runs on clk_sys.
// PARAMETERS
//  FILTER   8     clk_sys cycles ps2_clk must hold a new level before the level is accepted (>=2)
//  TIMEOUT  8192  max clk_sys cycles between falling edges inside a frame; must exceed 2*(PS2DIV+1)
// PORTS
//  clk_sys         in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  ps2_clk         in   1   PS/2 clock from the HPS I/O block; idles high
//  ps2_data        in   1   PS/2 data; valid at ps2_clk falling edge
//  ps2_byte        out  8   last good received byte
//  ps2_byte_valid  out  1   1-cycle pulse when ps2_byte is updated
//  frame_err       out  1   1-cycle pulse on parity, stop or timeout error
//  ps2_key         out  11  [10] toggle, [9] pressed, [8] extended, [7:0] code
// BEHAVIOUR
//  Reset: all outputs 0; RX state IDLE; prefix flags and pause_cnt cleared.
//  Reset mid-frame drops the partial frame; no frame_err pulse for it.
//  Input stage: 2-FF sync on both inputs, then the glitch filter on clk.
//  Filter: the level changes only after FILTER consecutive equal synced samples.
//  A filtered 1->0 transition gives a 1-cycle fall strobe. Synced data is sampled on that same cycle.
//  Frame: start(0), D0..D7 LSB first, odd parity, stop(1).
//  RX FSM:
//   IDLE: fall & data=0 -> DATA (bit_cnt=0). Fall & data=1 -> ignored, stay IDLE, no error.
//   DATA: shift in one bit per fall; after the 8th bit -> PARITY.
//   PARITY: store the bit -> STOP.
//   STOP: data=1 & ^{byte,parity}==1 -> byte good; otherwise frame_err. Always -> IDLE.
//  Good byte: ps2_byte and ps2_byte_valid update on the cycle after the stop-bit fall strobe.
//  Timeout: a counter clears on each fall strobe. In any state other than IDLE, reaching TIMEOUT
//   pulses frame_err and returns to IDLE. The counter is held at 0 in IDLE.
//  Decoder: registered stage, 1 cycle after ps2_byte_valid. Rules by byte:
//   FA,AA,EE,FE,00,FF: host responses; no event, prefix flags unchanged.
//   E0: ext=1.  F0: rel=1.
//   E1: pause_cnt=7. While pause_cnt!=0, each byte only decrements it.
//    When it reaches 0, emit pressed=1, extended=1, code=77.
//   Any other byte: emit pressed=~rel, extended=ext, code=byte; then clear ext and rel.
//  Emit: ps2_key[9:0] loaded and ps2_key[10] inverted in the same cycle; never more than 1 emit per byte.
//  Simultaneous timeout and fall strobe on the same cycle: the fall strobe wins and the counter clears.
//  All counters saturate or are sized so they cannot wrap: bit_cnt 3b, timeout $clog2(TIMEOUT+1)b.
// STRUCTURE
//  Shared package ps2_pkg:
//   prefix constants PS2_EXT=8'hE0, PS2_REL=8'hF0, PS2_PAUSE=8'hE1
//   host-response codes
//   RX state encoding (IDLE, DATA, PARITY, STOP)
//  Sub-module ps2_edge_filter (FILTER): 2-FF sync + glitch filter + fall strobe.
//   Instantiated once for clk; data uses a sync only.
//  RX FSM and decoder stay in this module.
// TESTING
//  BFM drives frames with PS2DIV=20, FILTER=4, TIMEOUT=200.
//  1. Frame 1C, good parity -> ps2_byte=1C pulse; then ps2_key=11'b1_1_0_00011100 (toggle 0->1).
//  2. Bytes E0,F0,75 -> one event {pressed=0, ext=1, code=75}. Toggle flips once; ps2_byte_valid pulses 3 times.
//  3. Parity bit inverted on frame 1C -> frame_err pulse, no ps2_byte_valid, ps2_key unchanged.
//     Stop=0 gives the same result.
//  4. Clock stopped after 4 data bits for 300 cycles -> frame_err at cycle 200.
//     A following frame 2A then decodes correctly.
//  5. E1,14,77,E1,F0,14,F0,77 -> one event {1,1,77}; 1-cycle clk glitches (<FILTER) inserted -> no effect.
//  6. FA, then reset asserted mid-frame of 1C -> no event.
//     After reset release, 1C decodes with toggle starting from 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, RX state encoding and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  // Set-2 prefix bytes
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_REL        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  // Code reported for the Pause key once its whole sequence has been swallowed
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  // Bytes that follow E1 before the Pause sequence is complete
  localparam logic [2:0] PS2_PAUSE_LEN  = 3'd7;

  // Host-response codes (keyboard replies to host commands, not key events)
  localparam logic [7:0] PS2_ACK        = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK     = 8'hAA;
  localparam logic [7:0] PS2_ECHO       = 8'hEE;
  localparam logic [7:0] PS2_RESEND     = 8'hFE;
  localparam logic [7:0] PS2_OVERRUN0   = 8'h00;
  localparam logic [7:0] PS2_OVERRUN1   = 8'hFF;

  // Frame receiver states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // True for bytes that never produce a key event and leave prefix flags alone
  function automatic logic is_host_response(input logic [7:0] b);
    return (b == PS2_ACK)    || (b == PS2_BAT_OK)   || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_OVERRUN0) || (b == PS2_OVERRUN1);
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// Two-flop synchroniser plus glitch filter for the PS/2 clock line.
// Produces a one-cycle strobe whenever the filtered level goes 1 -> 0.
module ps2_edge_filter #(
  parameter int FILTER = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic fall
);

  localparam int CW = $clog2(FILTER + 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic          fall_reg;
  logic [CW-1:0] cnt_reg;

  // Metastability guard; the line idles high so reset to 1 to avoid a fake edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], din};
    end
  end

  // Accept a new level only after FILTER consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      fall_reg  <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILTER - 1)) begin
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
        fall_reg  <= ~sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign fall = fall_reg;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame checking, timeout recovery and set-2 prefix decoding.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 8192
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [7:0]  ps2_byte,
  output logic        ps2_byte_valid,
  output logic        frame_err,
  output logic [10:0] ps2_key
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          fall;
  logic [1:0]    data_sync_reg;
  logic          data_s;

  rx_state_t     state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic [TW-1:0] tmo_cnt_reg;
  logic          byte_good;
  logic          err_next;

  logic [7:0]    byte_reg;
  logic          byte_valid_reg;
  logic          frame_err_reg;

  logic [10:0]   key_reg, key_next;
  logic          ext_reg, ext_next;
  logic          rel_reg, rel_next;
  logic [2:0]    pause_reg, pause_next;

  ps2_edge_filter #(
    .FILTER (FILTER)
  ) u_clk_filter (
    .clk   (clk_sys),
    .reset (reset),
    .din   (ps2_clk),
    .fall  (fall)
  );

  // Data only needs synchronising; it is stable long before the filtered clock edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      data_sync_reg <= 2'b11;
    end else begin
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  assign data_s = data_sync_reg[1];

  // Frame receiver state and datapath registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
    end
  end

  // Frame receiver next state: one step per fall strobe, timeout otherwise
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    byte_good    = 1'b0;
    err_next     = 1'b0;
    if (fall) begin
      case (state_reg)
        IDLE: begin
          if (!data_s) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next = {data_s, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
        PARITY: begin
          parity_next = data_s;
          state_next  = STOP;
        end
        STOP: begin
          if (data_s && (^{shift_reg, parity_reg})) begin
            byte_good = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if ((state_reg != IDLE) && (tmo_cnt_reg == TW'(TIMEOUT))) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end
  end

  // Inter-edge watchdog: parked at 0 in IDLE, cleared by every fall strobe, saturates
  always_ff @(posedge clk_sys) begin
    if (reset || fall || (state_reg == IDLE)) begin
      tmo_cnt_reg <= '0;
    end else if (tmo_cnt_reg != TW'(TIMEOUT)) begin
      tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
    end
  end

  // Registered byte and error pulses, one cycle after the stop-bit strobe
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      byte_reg       <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= byte_good;
      frame_err_reg  <= err_next;
      if (byte_good) begin
        byte_reg <= shift_reg;
      end
    end
  end

  // Scancode decoder: prefix tracking, Pause swallowing and event emission
  always_comb begin
    key_next   = key_reg;
    ext_next   = ext_reg;
    rel_next   = rel_reg;
    pause_next = pause_reg;
    if (byte_valid_reg) begin
      if (pause_reg != 3'd0) begin
        pause_next = pause_reg - 3'd1;
        if (pause_reg == 3'd1) begin
          key_next = {~key_reg[10], 1'b1, 1'b1, PS2_PAUSE_CODE};
        end
      end else if (is_host_response(byte_reg)) begin
        pause_next = pause_reg;
      end else if (byte_reg == PS2_EXT) begin
        ext_next = 1'b1;
      end else if (byte_reg == PS2_REL) begin
        rel_next = 1'b1;
      end else if (byte_reg == PS2_PAUSE) begin
        pause_next = PS2_PAUSE_LEN;
      end else begin
        key_next = {~key_reg[10], ~rel_reg, ext_reg, byte_reg};
        ext_next = 1'b0;
        rel_next = 1'b0;
      end
    end
  end

  // Decoder registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_reg   <= '0;
      ext_reg   <= 1'b0;
      rel_reg   <= 1'b0;
      pause_reg <= '0;
    end else begin
      key_reg   <= key_next;
      ext_reg   <= ext_next;
      rel_reg   <= rel_next;
      pause_reg <= pause_next;
    end
  end

  assign ps2_byte       = byte_reg;
  assign ps2_byte_valid = byte_valid_reg;
  assign frame_err      = frame_err_reg;
  assign ps2_key        = key_reg;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: PS/2 frame BFM, queue-based reference model,
// per-cycle compare process, directed scenarios then randomized frames.
module tb_ps2_kbd_rx;

  localparam int PS2DIV  = 20;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [7:0]  ps2_byte;
  logic        ps2_byte_valid;
  logic        frame_err;
  logic [10:0] ps2_key;

  ps2_kbd_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_sys        (clk),
    .reset          (reset),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .ps2_byte       (ps2_byte),
    .ps2_byte_valid (ps2_byte_valid),
    .frame_err      (frame_err),
    .ps2_key        (ps2_key)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_fall = 0;

  always @(posedge clk) cyc++;

  // Reference model state
  logic [7:0]  exp_bytes[$];
  logic [10:0] exp_keys[$];
  int          exp_errs = 0;
  bit          m_ext = 0, m_rel = 0, m_tog = 0;
  int          m_pause = 0;
  logic [10:0] m_key = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h, expected nothing (cycle %0d)", name, act, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_emit(input bit pressed, input bit ext, input logic [7:0] code);
    m_tog = ~m_tog;
    m_key = {m_tog, pressed, ext, code};
    exp_keys.push_back(m_key);
  endtask

  // Key-event rules applied to one accepted byte
  task automatic model_byte(input logic [7:0] b);
    if (m_pause != 0) begin
      m_pause = m_pause - 1;
      if (m_pause == 0) model_emit(1'b1, 1'b1, 8'h77);
    end else if (b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF) begin
      m_pause = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else if (b == 8'hE1) begin
      m_pause = 7;
    end else begin
      model_emit(~m_rel, m_ext, b);
      m_ext = 0;
      m_rel = 0;
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_rel = 0; m_tog = 0; m_pause = 0; m_key = '0;
    exp_bytes.delete();
    exp_keys.delete();
    exp_errs = 0;
  endtask

  // Drive the first nbits of a frame; optional 1-cycle glitches mid-phase
  task automatic drive_bits(input logic [10:0] bits, input int nbits, input bit gl);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(PS2DIV / 2);
      if (gl) begin ps2_clk = 1'b0; tick(1); ps2_clk = 1'b1; end
      tick(PS2DIV / 2);
      ps2_clk = 1'b0;
      last_fall = cyc;
      tick(PS2DIV / 2);
      if (gl) begin ps2_clk = 1'b1; tick(1); ps2_clk = 1'b0; end
      tick(PS2DIV / 2);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_full(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit gl);
    if (!bad_par && !bad_stop) begin
      exp_bytes.push_back(b);
      model_byte(b);
    end else begin
      exp_errs++;
    end
    drive_bits(frame_bits(b, bad_par, bad_stop), 11, gl);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_bytes.size() != 0 || exp_keys.size() != 0 || exp_errs != 0) && n < 3000) begin
      tick(1);
      n++;
    end
    check({tag, "_pending"}, exp_bytes.size() + exp_keys.size() + exp_errs, 0);
    exp_bytes.delete();
    exp_keys.delete();
    exp_errs = 0;
    tick(20);
  endtask

  // Compare process: every DUT pulse / key change is matched against the model queues
  logic [10:0] prev_key = '0;
  bit          prev_valid = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_key   = ps2_key;
      prev_valid = 0;
    end else begin
      if (ps2_byte_valid) begin
        if (prev_valid) flag("byte_valid_width", ps2_byte_valid);
        if (exp_bytes.size() == 0) flag("unexpected_byte", ps2_byte);
        else check("ps2_byte", ps2_byte, exp_bytes.pop_front());
      end
      if (frame_err) begin
        if (exp_errs == 0) flag("unexpected_frame_err", frame_err);
        else begin
          exp_errs--;
          n_checks++;
        end
      end
      if (ps2_key !== prev_key) begin
        check("key_after_valid", prev_valid, 1);
        if (exp_keys.size() == 0) flag("unexpected_key", ps2_key);
        else check("ps2_key", ps2_key, exp_keys.pop_front());
      end
      prev_key   = ps2_key;
      prev_valid = ps2_byte_valid;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] picks [9] = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    logic [7:0] seq5 [8]  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    int lat;
    bit seen;

    // Reset state
    tick(4);
    check("reset_byte", ps2_byte, 0);
    check("reset_valid", ps2_byte_valid, 0);
    check("reset_err", frame_err, 0);
    check("reset_key", ps2_key, 0);
    reset = 1'b0;
    tick(10);

    // 1: single make code
    send_full(8'h1C, 0, 0, 0);
    drain("t1");
    check("t1_key", ps2_key, 11'b1_1_0_00011100);
    check("t1_model", m_key, 11'b1_1_0_00011100);
    check("t1_byte", ps2_byte, 8'h1C);

    // 2: extended break code
    send_full(8'hE0, 0, 0, 0);
    send_full(8'hF0, 0, 0, 0);
    send_full(8'h75, 0, 0, 0);
    drain("t2");
    check("t2_key", ps2_key, 11'b0_0_1_01110101);
    check("t2_model", m_key, 11'b0_0_1_01110101);

    // 3: bad parity, then bad stop
    send_full(8'h1C, 1, 0, 0);
    send_full(8'h1C, 0, 1, 0);
    drain("t3");
    check("t3_key", ps2_key, 11'b0_0_1_01110101);

    // 4: clock stops after 4 data bits
    exp_errs++;
    drive_bits(frame_bits(8'h55, 0, 0), 5, 0);
    seen = 0;
    lat = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick(1);
      if (frame_err) begin
        seen = 1;
        lat = cyc - last_fall;
      end
    end
    check("t4_err_seen", seen, 1);
    check("t4_err_window", (lat >= TIMEOUT && lat <= TIMEOUT + FILTER + 10), 1);
    tick(300 - lat);
    send_full(8'h2A, 0, 0, 0);
    drain("t4");
    check("t4_key", ps2_key, 11'b1_1_0_00101010);

    // 5: Pause sequence with clock glitches
    for (int i = 0; i < 8; i++) send_full(seq5[i], 0, 0, 1);
    drain("t5");
    check("t5_key", ps2_key, 11'b0_1_1_01110111);
    check("t5_model", m_key, 11'b0_1_1_01110111);

    // 6: host response, then reset in the middle of a frame
    send_full(8'hFA, 0, 0, 0);
    drain("t6a");
    check("t6_key_fa", ps2_key, 11'b0_1_1_01110111);
    drive_bits(frame_bits(8'h1C, 0, 0), 5, 0);
    tick(3);
    reset = 1'b1;
    tick(3);
    check("t6_rst_key", ps2_key, 0);
    check("t6_rst_byte", ps2_byte, 0);
    check("t6_rst_valid", ps2_byte_valid, 0);
    check("t6_rst_err", frame_err, 0);
    model_reset();
    reset = 1'b0;
    tick(10);
    send_full(8'h1C, 0, 0, 0);
    drain("t6");
    check("t6_key", ps2_key, 11'b1_1_0_00011100);

    // Randomized frames
    for (int n = 0; n < 50; n++) begin
      logic [7:0] b;
      int e;
      b = ($urandom_range(0, 9) < 4) ? picks[$urandom_range(0, 8)] : 8'($urandom);
      e = $urandom_range(0, 9);
      send_full(b, e == 0, e == 1, 1'($urandom_range(0, 1)));
      tick($urandom_range(0, 50));
    end
    drain("rand");
    check("rand_key", ps2_key, m_key);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
